// File: rtl/ring_osc_meter.sv
// Ring oscillator frequency meter: synchronizes osc_in, counts its rising edges
// over a GATE_CYCLES-long window and reports the saturating count with a valid strobe.
module ring_osc_meter #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;
    logic                   osc_edge;
    logic                   arm;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], osc_in};
        hist_d     = sync_q[SYNC_STAGES-1];
        osc_edge   = sync_q[SYNC_STAGES-1] & ~hist_q;
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        arm        = 1'b0;

        case (state_q)
            IDLE: arm = start | continuous;
            GATE: begin
                gate_cnt_d = gate_cnt_q + GW'(1);
                if (osc_edge) begin
                    if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
                    else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                // The final-cycle edge is folded into the published result here.
                if (gate_cnt_q == GATE_LAST) begin
                    state_d    = DONE;
                    valid_d    = 1'b1;
                    count_d    = edge_cnt_d;
                    overflow_d = sat_d;
                end
            end
            DONE: begin
                arm = continuous;
                if (!continuous) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (arm) begin
            state_d    = GATE;
            busy_d     = 1'b1;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_ring_osc_meter.sv
// Bench for ring_osc_meter: records every sampled osc_in value and predicts each
// result by counting rising transitions in the latency-shifted gate window.
module tb_ring_osc_meter;
    localparam int G    = 64;
    localparam int CW   = 4;
    localparam int SS   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0, rst = 1'b0, osc_in = 1'b0, start = 1'b0, continuous = 1'b0;
    logic [CW-1:0] count;
    logic          valid, busy, overflow;

    int   errors = 0, checks = 0;
    int   cyc = 0;
    bit   samp [0:65535];
    int   osc_mode = 0;
    logic osc_static = 1'b0;
    int   osc_hi = 4, osc_lo = 4, osc_ctr = 0;

    ring_osc_meter #(.GATE_CYCLES(G), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
        .count(count), .valid(valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Sample k is what the synchronizer front flop captures at posedge k.
    always @(posedge clk) begin
        if (cyc < 65536) samp[cyc] = rst ? 1'b0 : osc_in;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        case (osc_mode)
            0: osc_in = osc_static;
            1: begin
                osc_ctr = osc_ctr + 1;
                if (osc_in && osc_ctr >= osc_hi) begin osc_in = 1'b0; osc_ctr = 0; end
                else if (!osc_in && osc_ctr >= osc_lo) begin osc_in = 1'b1; osc_ctr = 0; end
            end
            default: osc_in = 1'($urandom);
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // A rise sampled at posedge k is seen by the gate counter at posedge k+SS,
    // so the gate opened at c0 covers samples c0+1-SS .. c0+G-SS.
    function automatic int model_edges(input int c0);
        int n = 0;
        for (int k = c0 + 1 - SS; k <= c0 + G - SS; k++)
            if (samp[k] && !samp[k-1]) n++;
        return n;
    endfunction

    task automatic do_start(output int c0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c0 = cyc - 1;
    endtask

    task automatic wait_valid(input int c0, output int v, output logic [CW-1:0] cnt,
                              output logic ovf, output int be);
        v = -1; cnt = '0; ovf = 1'b0; be = 0;
        for (int i = 0; i < G + 10; i++) begin
            if (valid === 1'b1) begin
                v = cyc - 1; cnt = count; ovf = overflow;
                break;
            end
            if (busy !== 1'b1) be++;
            @(negedge clk);
        end
    endtask

    task automatic measure(output int c0, output int v, output logic [CW-1:0] cnt, output logic ovf,
                           output int be, output logic [CW-1:0] ecnt, output logic eovf);
        int n;
        do_start(c0);
        wait_valid(c0, v, cnt, ovf, be);
        n    = model_edges(c0);
        ecnt = (n > CMAX) ? CW'(CMAX) : CW'(n);
        eovf = (n > CMAX);
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++; if (count !== '0)     begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || valid !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, valid); end
    endtask

    task automatic test_steady;
        int c0, v, be; logic [CW-1:0] cnt, ecnt; logic ovf, eovf;
        osc_mode = 1; osc_hi = 4; osc_lo = 4;
        repeat (10) @(negedge clk);
        measure(c0, v, cnt, ovf, be, ecnt, eovf);
        checks++; if (v !== c0 + G) begin errors++; $display("FAIL steady_latency: got %0d want %0d", v, c0 + G); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL steady_count: got %0d want 8", cnt); end
        checks++; if (cnt !== ecnt) begin errors++; $display("FAIL steady_model: got %0d want %0d", cnt, ecnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL steady_overflow: got %b want 0", ovf); end
        checks++; if (be !== 0)     begin errors++; $display("FAIL steady_busy: %0d low cycles want 0", be); end
        @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL steady_after: valid=%b busy=%b want 0 0", valid, busy); end
    endtask

    task automatic test_static;
        int c0, v, be; logic [CW-1:0] cnt, ecnt; logic ovf, eovf;
        for (int s = 0; s < 2; s++) begin
            osc_mode = 0; osc_static = 1'(s);
            repeat (10) @(negedge clk);
            measure(c0, v, cnt, ovf, be, ecnt, eovf);
            checks++; if (v !== c0 + G) begin errors++; $display("FAIL static%0d_latency: got %0d want %0d", s, v, c0 + G); end
            checks++; if (cnt !== '0 || cnt !== ecnt) begin errors++; $display("FAIL static%0d_count: got %0d want 0", s, cnt); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL static%0d_overflow: got %b want 0", s, ovf); end
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL static%0d_busy_after: got %b want 0", s, busy); end
        end
    endtask

    task automatic test_saturation;
        int c0, v, be; logic [CW-1:0] cnt, ecnt; logic ovf, eovf;
        osc_mode = 1; osc_hi = 1; osc_lo = 1;
        repeat (10) @(negedge clk);
        measure(c0, v, cnt, ovf, be, ecnt, eovf);
        checks++; if (cnt !== 4'd15 || cnt !== ecnt) begin errors++; $display("FAIL sat_count: got %0d want 15", cnt); end
        checks++; if (ovf !== 1'b1 || ovf !== eovf) begin errors++; $display("FAIL sat_overflow: got %b want 1", ovf); end
        osc_mode = 0; osc_static = 1'b0;
        repeat (10) @(negedge clk);
        measure(c0, v, cnt, ovf, be, ecnt, eovf);
        checks++; if (v !== c0 + G) begin errors++; $display("FAIL sat_clear_latency: got %0d want %0d", v, c0 + G); end
        checks++; if (cnt !== '0 || ovf !== 1'b0)
            begin errors++; $display("FAIL sat_clear: count=%0d overflow=%b want 0 0", cnt, ovf); end
    endtask

    task automatic test_continuous;
        int c0, v, be, n, extra; logic [CW-1:0] cnt; logic ovf;
        osc_mode = 1; osc_hi = 4; osc_lo = 4;
        repeat (10) @(negedge clk);
        continuous = 1'b1;
        @(negedge clk);
        c0 = cyc - 1;
        for (int p = 0; p < 3; p++) begin
            wait_valid(c0, v, cnt, ovf, be);
            n = model_edges(c0);
            checks++; if (v !== c0 + G) begin errors++; $display("FAIL cont%0d_period: got %0d want %0d", p, v, c0 + G); end
            checks++; if (cnt !== CW'(n) || ovf !== 1'b0)
                begin errors++; $display("FAIL cont%0d_result: count=%0d ovf=%b want %0d 0", p, cnt, ovf, n); end
            @(negedge clk);
            checks++; if (valid !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL cont%0d_rearm: valid=%b busy=%b want 0 1", p, valid, busy); end
            c0 = c0 + G + 1;
        end
        repeat (20) @(negedge clk);
        continuous = 1'b0;
        wait_valid(c0, v, cnt, ovf, be);
        n = model_edges(c0);
        checks++; if (v !== c0 + G || cnt !== CW'(n))
            begin errors++; $display("FAIL cont_last: at %0d count=%0d want at %0d count=%0d", v, cnt, c0 + G, n); end
        extra = 0;
        for (int i = 0; i < 2 * G; i++) begin
            @(negedge clk);
            if (valid === 1'b1 || busy !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL cont_stop: %0d active cycles after stop want 0", extra); end
    endtask

    task automatic test_ignored_start;
        int c0, rel, nval, vfirst; logic [CW-1:0] cfirst;
        osc_mode = 1; osc_hi = 3; osc_lo = 5;
        repeat (10) @(negedge clk);
        do_start(c0);
        nval = 0; vfirst = -1; cfirst = '0;
        for (int i = 0; i < 3 * G; i++) begin
            rel   = cyc - 1 - c0;
            start = (rel == 5 || rel == 30 || rel == G - 1 || rel == G);
            if (valid === 1'b1) begin
                nval++;
                if (vfirst < 0) begin vfirst = cyc - 1; cfirst = count; end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (nval !== 1) begin errors++; $display("FAIL ignored_start_count: got %0d valids want 1", nval); end
        checks++; if (vfirst !== c0 + G) begin errors++; $display("FAIL ignored_start_latency: got %0d want %0d", vfirst, c0 + G); end
        checks++; if (cfirst !== CW'(model_edges(c0)))
            begin errors++; $display("FAIL ignored_start_result: got %0d want %0d", cfirst, model_edges(c0)); end
    endtask

    task automatic test_reset_mid;
        int c0, v, be; logic [CW-1:0] cnt, ecnt, prev; logic ovf, eovf;
        osc_mode = 1; osc_hi = 4; osc_lo = 4;
        prev = count;
        do_start(c0);
        repeat (29) @(negedge clk);
        checks++; if (busy !== 1'b1 || count !== prev)
            begin errors++; $display("FAIL midgate_pre: busy=%b count=%0d want 1 %0d", busy, count, prev); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || count !== '0 || overflow !== 1'b0)
            begin errors++; $display("FAIL midgate_async: busy=%b valid=%b count=%0d ovf=%b want all 0", busy, valid, count, overflow); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        measure(c0, v, cnt, ovf, be, ecnt, eovf);
        checks++; if (v !== c0 + G) begin errors++; $display("FAIL midgate_latency: got %0d want %0d", v, c0 + G); end
        checks++; if (cnt !== ecnt || ovf !== eovf)
            begin errors++; $display("FAIL midgate_result: count=%0d ovf=%b want %0d %b", cnt, ovf, ecnt, eovf); end
    endtask

    task automatic test_random;
        int c0, v, be; logic [CW-1:0] cnt, ecnt; logic ovf, eovf;
        for (int it = 0; it < 8; it++) begin
            if (it < 4) begin
                osc_mode = 1;
                osc_hi   = $urandom_range(1, 9);
                osc_lo   = $urandom_range(1, 9);
            end else begin
                osc_mode = 2;
            end
            repeat ($urandom_range(3, 20)) @(negedge clk);
            measure(c0, v, cnt, ovf, be, ecnt, eovf);
            checks++; if (v !== c0 + G) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, v, c0 + G); end
            checks++; if (cnt !== ecnt) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, cnt, ecnt); end
            checks++; if (ovf !== eovf) begin errors++; $display("FAIL rand%0d_overflow: got %b want %b", it, ovf, eovf); end
            checks++; if (be !== 0)     begin errors++; $display("FAIL rand%0d_busy: %0d low cycles want 0", it, be); end
        end
    endtask

    initial begin
        test_reset;
        test_steady;
        test_static;
        test_saturation;
        test_continuous;
        test_ignored_start;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
